// File: rtl/l2_pkg.sv
// l2_pkg: shared widths and FSM state encoding for the fully associative L2 responder.
package l2_pkg;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 16;
   localparam int ENTRIES = 8;
   localparam int AGE_W   = $clog2(ENTRIES);
   typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, INSTALL, RESP} state_t;
endpackage

// File: rtl/cache_l2_fa_responder_if.sv
// cache_l2_fa_responder_if: L1 request channel and req/ack memory port of the L2 responder.
interface cache_l2_fa_responder_if;
   import l2_pkg::*;
   logic              l1_req;
   logic              l1_we;
   logic [ADDR_W-1:0] l1_addr;
   logic [DATA_W-1:0] l1_wdata;
   logic              l1_ack;
   logic [DATA_W-1:0] l1_rdata;
   logic              l1_hit;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   modport slave (
      input  l1_req, l1_we, l1_addr, l1_wdata, mem_rdata, mem_ack,
      output l1_ack, l1_rdata, l1_hit, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output l1_req, l1_we, l1_addr, l1_wdata, mem_rdata, mem_ack,
      input  l1_ack, l1_rdata, l1_hit, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/l2_lru_ages.sv
// l2_lru_ages: per-entry age counters for true LRU; ages always form a permutation of 0..ENTRIES-1.
module l2_lru_ages
   import l2_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          upd,
   input  logic [AGE_W-1:0]              idx,
   output logic [AGE_W-1:0]              oldest,
   output logic [ENTRIES-1:0][AGE_W-1:0] ages
);
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < ENTRIES; i++) ages[i] <= AGE_W'(i);
      else if (upd)
         for (int i = 0; i < ENTRIES; i++)
            ages[i] <= (AGE_W'(i) == idx) ? '0 : (ages[i] < ages[idx]) ? ages[i] + 1'b1 : ages[i];
   always_comb begin
      oldest = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (ages[i] == AGE_W'(ENTRIES - 1)) oldest = AGE_W'(i);
   end
endmodule

// File: rtl/cache_l2_fa_responder.sv
// cache_l2_fa_responder: 8-entry fully associative write-back/write-allocate L2 serving L1 requests.
// Define L2_STATS_EN to add saturating stat_hits/stat_misses counters.
module cache_l2_fa_responder
   import l2_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   cache_l2_fa_responder_if.slave  bus
`ifdef L2_STATS_EN
   ,
   output logic [15:0]             stat_hits,
   output logic [15:0]             stat_misses
`endif
);
   state_t                          state;
   logic [ENTRIES-1:0]              valid, dirty;
   logic [ENTRIES-1:0][ADDR_W-1:0]  tags;
   logic [ENTRIES-1:0][DATA_W-1:0]  data;
   logic [ADDR_W-1:0]               addr;
   logic                            we;
   logic [DATA_W-1:0]               wdata;
   logic [AGE_W-1:0]                v, hit_idx, inv_idx, oldest, victim, upd_idx;
   logic                            hit, has_inv, upd, fill_done;
   logic [ENTRIES-1:0][AGE_W-1:0]   ages_unused;

   // descending scan leaves the lowest matching/invalid index as the result
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      has_inv = 1'b0;
      inv_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && tags[i] == addr) begin
            hit = 1'b1;
            hit_idx = AGE_W'(i);
         end
         if (!valid[i]) begin
            has_inv = 1'b1;
            inv_idx = AGE_W'(i);
         end
      end
   end

   assign victim    = has_inv ? inv_idx : oldest;
   assign fill_done = state == FILL && bus.mem_req && bus.mem_ack;
   assign upd       = (state == LOOKUP && hit) || fill_done || state == INSTALL;
   assign upd_idx   = state == LOOKUP ? hit_idx : v;

   l2_lru_ages u_ages (
      .clk    (clk),
      .reset  (reset),
      .upd    (upd),
      .idx    (upd_idx),
      .oldest (oldest),
      .ages   (ages_unused)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         valid         <= '0;
         dirty         <= '0;
         tags          <= '0;
         data          <= '0;
         addr          <= '0;
         we            <= 1'b0;
         wdata         <= '0;
         v             <= '0;
         bus.l1_ack    <= 1'b0;
         bus.l1_hit    <= 1'b0;
         bus.l1_rdata  <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else
         case (state)
            IDLE:
               if (bus.l1_req) begin
                  addr  <= bus.l1_addr;
                  we    <= bus.l1_we;
                  wdata <= bus.l1_wdata;
                  state <= LOOKUP;
               end
            LOOKUP:
               if (hit) begin
                  bus.l1_hit   <= 1'b1;
                  bus.l1_rdata <= we ? wdata : data[hit_idx];
                  bus.l1_ack   <= 1'b1;
                  if (we) begin
                     data[hit_idx]  <= wdata;
                     dirty[hit_idx] <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  bus.l1_hit <= 1'b0;
                  v          <= victim;
                  if (valid[victim] && dirty[victim]) begin
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= tags[victim];
                     bus.mem_wdata <= data[victim];
                     state         <= WB;
                  end else if (we)
                     state <= INSTALL;
                  else begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_we   <= 1'b0;
                     bus.mem_addr <= addr;
                     state        <= FILL;
                  end
               end
            WB:
               if (bus.mem_ack) begin
                  dirty[v]     <= 1'b0;
                  bus.mem_req  <= 1'b0;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= addr;
                  state        <= we ? INSTALL : FILL;
               end
            // after a write-back the read request is raised one cycle later
            FILL:
               if (!bus.mem_req)
                  bus.mem_req <= 1'b1;
               else if (bus.mem_ack) begin
                  tags[v]      <= addr;
                  data[v]      <= bus.mem_rdata;
                  valid[v]     <= 1'b1;
                  dirty[v]     <= 1'b0;
                  bus.l1_rdata <= bus.mem_rdata;
                  bus.mem_req  <= 1'b0;
                  bus.l1_ack   <= 1'b1;
                  state        <= RESP;
               end
            INSTALL: begin
               tags[v]      <= addr;
               data[v]      <= wdata;
               valid[v]     <= 1'b1;
               dirty[v]     <= 1'b1;
               bus.l1_rdata <= wdata;
               bus.l1_ack   <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               bus.l1_ack <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

`ifdef L2_STATS_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (state == LOOKUP) begin
         if (hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 1'b1;
         if (!hit && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 1'b1;
      end
`endif
endmodule
